// File: rtl/calc1_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : calc1_port_responder_if
// Description : calc1 command/data port bundle between a requester (master)
//               and the single-port responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface calc1_port_responder_if;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  resp_out;
    logic [31:0] data_out;
    logic        busy;
    logic        cmd_drop;

    modport master (
        output cmd_in,
        output data_in,
        input  resp_out,
        input  data_out,
        input  busy,
        input  cmd_drop
    );

    modport slave (
        input  cmd_in,
        input  data_in,
        output resp_out,
        output data_out,
        output busy,
        output cmd_drop
    );
endinterface
`default_nettype wire

// File: rtl/calc1_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : calc1_port_responder
// Description : calc1 single-port responder: command+op1, op2, execute, one
//               cycle response. Define CALC1_SHIFT_EN to build the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_port_responder (
    input wire                     clk,
    input wire                     reset,
    calc1_port_responder_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OPND2 = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [3:0] c_CMD_ADD = 4'd1;
    localparam logic [3:0] c_CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
    localparam logic [3:0] c_CMD_SHL = 4'd5;
    localparam logic [3:0] c_CMD_SHR = 4'd6;
`endif

    localparam logic [1:0] c_RESP_NONE    = 2'd0;
    localparam logic [1:0] c_RESP_OK      = 2'd1;
    localparam logic [1:0] c_RESP_OVF     = 2'd2;
    localparam logic [1:0] c_RESP_INVALID = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [1:0]  r_resp;
    logic [31:0] r_data;
    logic        r_cmd_drop;
    logic        w_busy;
    logic        w_accept;
    logic        w_cmd_valid;
    logic [32:0] w_sum;
    logic [1:0]  w_resp;
    logic [31:0] w_result;

    assign w_cmd_valid = (bus.cmd_in != 4'd0);
    // A new request may start from IDLE or overlap the response cycle.
    assign w_accept    = w_cmd_valid && ((r_state == c_IDLE) || (r_state == c_RESP));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  w_next_state = w_accept ? c_OPND2 : c_IDLE;
            c_OPND2: w_next_state = c_EXEC;
            c_EXEC:  w_next_state = c_RESP;
            c_RESP:  w_next_state = w_accept ? c_OPND2 : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            c_OPND2, c_EXEC: w_busy = 1'b1;
            default:         w_busy = 1'b0;
        endcase
    end

    // Execute stage; unsupported codes fall through to invalid.
    always_comb begin
        w_sum    = {1'b0, r_op1} + {1'b0, r_op2};
        w_resp   = c_RESP_INVALID;
        w_result = 32'd0;
        case (r_cmd)
            c_CMD_ADD: begin
                if (w_sum[32]) begin
                    w_resp = c_RESP_OVF;
                end else begin
                    w_resp   = c_RESP_OK;
                    w_result = w_sum[31:0];
                end
            end
            c_CMD_SUB: begin
                if (r_op2 > r_op1) begin
                    w_resp = c_RESP_OVF;
                end else begin
                    w_resp   = c_RESP_OK;
                    w_result = r_op1 - r_op2;
                end
            end
`ifdef CALC1_SHIFT_EN
            c_CMD_SHL: begin
                w_resp   = c_RESP_OK;
                w_result = r_op1 << r_op2[4:0];
            end
            c_CMD_SHR: begin
                w_resp   = c_RESP_OK;
                w_result = r_op1 >> r_op2[4:0];
            end
`endif
            default: begin
                w_resp   = c_RESP_INVALID;
                w_result = 32'd0;
            end
        endcase
    end

    // Operand capture and one-cycle registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd      <= 4'd0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_resp     <= c_RESP_NONE;
            r_data     <= 32'd0;
            r_cmd_drop <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd <= bus.cmd_in;
                r_op1 <= bus.data_in;
            end
            if (r_state == c_OPND2) begin
                r_op2 <= bus.data_in;
            end
            if (r_state == c_EXEC) begin
                r_resp <= w_resp;
                r_data <= (w_resp == c_RESP_OK) ? w_result : 32'd0;
            end else begin
                r_resp <= c_RESP_NONE;
                r_data <= 32'd0;
            end
            r_cmd_drop <= w_cmd_valid && w_busy;
        end
    end

    assign bus.resp_out = r_resp;
    assign bus.data_out = r_data;
    assign bus.busy     = w_busy;
    assign bus.cmd_drop = r_cmd_drop;

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc1_port_responder
// Description : Directed self-checking bench for calc1_port_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_port_responder;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    calc1_port_responder_if bus ();

    calc1_port_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full request with idle command lines during op2/exec; checks busy 1,1,0
    // and the one-cycle response window.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data);
        bus.cmd_in  = cmd;
        bus.data_in = op1;
        step();
        chk({tag, " busy_opnd2"}, {31'd0, bus.busy}, 32'd1);
        bus.cmd_in  = 4'd0;
        bus.data_in = op2;
        step();
        chk({tag, " busy_exec"}, {31'd0, bus.busy}, 32'd1);
        bus.data_in = 32'd0;
        step();
        chk({tag, " resp"}, {30'd0, bus.resp_out}, {30'd0, exp_resp});
        chk({tag, " data"}, bus.data_out, exp_data);
        chk({tag, " busy_resp"}, {31'd0, bus.busy}, 32'd0);
        step();
        chk({tag, " resp_after"}, {30'd0, bus.resp_out}, 32'd0);
        chk({tag, " data_after"}, bus.data_out, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd0;
        step();
        step();
        step();
        reset = 1'b0;
        chk("reset resp", {30'd0, bus.resp_out}, 32'd0);
        chk("reset data", bus.data_out, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset cmd_drop", {31'd0, bus.cmd_drop}, 32'd0);

        run_op("add1+2", 4'd1, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h0000_0003);
        run_op("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000);
        run_op("add_max", 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF);
        run_op("sub5-7", 4'd2, 32'd5, 32'd7, 2'd2, 32'd0);
        run_op("sub7-7", 4'd2, 32'd7, 32'd7, 2'd1, 32'd0);
        run_op("sub9-4", 4'd2, 32'd9, 32'd4, 2'd1, 32'd5);
`ifdef CALC1_SHIFT_EN
        run_op("shl", 4'd5, 32'h8000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002);
        run_op("shr", 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001);
`else
        run_op("shl", 4'd5, 32'h8000_0001, 32'h0000_0021, 2'd3, 32'h0000_0000);
        run_op("shr", 4'd6, 32'h8000_0000, 32'd31, 2'd3, 32'h0000_0000);
`endif
        run_op("cmd9", 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 32'h0000_0000);

        // Commands during OPND2 and EXEC are dropped
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd20;
        step();
        chk("drop cmd_drop_opnd2", {31'd0, bus.cmd_drop}, 32'd0);
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd22;
        step();
        chk("drop cmd_drop_1", {31'd0, bus.cmd_drop}, 32'd1);
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd99;
        step();
        chk("drop cmd_drop_2", {31'd0, bus.cmd_drop}, 32'd1);
        chk("drop resp", {30'd0, bus.resp_out}, 32'd1);
        chk("drop data", bus.data_out, 32'd42);
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd0;
        step();
        chk("drop cmd_drop_clear", {31'd0, bus.cmd_drop}, 32'd0);
        chk("drop single_resp", {30'd0, bus.resp_out}, 32'd0);
        chk("drop busy_idle", {31'd0, bus.busy}, 32'd0);

        // Back-to-back: second add presented in the RESP cycle
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd10;
        step();
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd20;
        step();
        bus.data_in = 32'd0;
        step();
        chk("b2b resp1", {30'd0, bus.resp_out}, 32'd1);
        chk("b2b data1", bus.data_out, 32'd30);
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'h0000_0064;
        step();
        chk("b2b busy_opnd2", {31'd0, bus.busy}, 32'd1);
        chk("b2b resp_gap", {30'd0, bus.resp_out}, 32'd0);
        chk("b2b cmd_drop", {31'd0, bus.cmd_drop}, 32'd0);
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'h0000_0200;
        step();
        chk("b2b busy_exec", {31'd0, bus.busy}, 32'd1);
        bus.data_in = 32'd0;
        step();
        chk("b2b resp2", {30'd0, bus.resp_out}, 32'd1);
        chk("b2b data2", bus.data_out, 32'h0000_0264);
        chk("b2b busy_resp", {31'd0, bus.busy}, 32'd0);
        step();
        chk("b2b resp_after", {30'd0, bus.resp_out}, 32'd0);

        // Reset during EXEC discards the request
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd3;
        step();
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd4;
        step();
        bus.data_in = 32'd0;
        reset = 1'b1;
        step();
        chk("rst_mid resp", {30'd0, bus.resp_out}, 32'd0);
        chk("rst_mid data", bus.data_out, 32'd0);
        chk("rst_mid busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("rst_mid late_resp", {30'd0, bus.resp_out}, 32'd0);
        chk("rst_mid late_busy", {31'd0, bus.busy}, 32'd0);
        run_op("add_after_rst", 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc1_port_responder.md
# calc1_port_responder

Single-port responder for the calc1 command/data protocol: accepts a command with operand 1, takes operand 2 on the following cycle, executes it, and returns a response code plus result. It is the device side that the calc1 stimulus benches drive through `cmd_in`/`data_in` and sample on `data_out`. It is the building block for the multi-port calc1 core.

## Interface
- No parameters; data width fixed at 32, command 4 bits, response 2 bits.
- `clk` input 1 – sole clock, all logic on rising edge.
- `reset` input 1 – synchronous, active-high; clears all state.
- `cmd_in` input 4 – command; nonzero = request, sampled together with operand 1.
- `data_in` input 32 – operand 1 in command cycle, operand 2 the next cycle.
- `resp_out` output 2 – 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- `data_out` output 32 – result, valid only when `resp_out` is 1; otherwise 0.
- `busy` output 1 – high while a request is between acceptance and response.
- `cmd_drop` output 1 – one-cycle pulse when a nonzero `cmd_in` is ignored.

## Operation
- Commands: 1 add, 2 subtract, 5 shift left, 6 shift right; other nonzero codes are invalid.
- States: IDLE, OPND2, EXEC, RESP.
  - IDLE: nonzero `cmd_in` → latch cmd and op1, go to OPND2.
  - OPND2: latch `data_in` as op2 unconditionally → EXEC. A nonzero `cmd_in` here is ignored and pulses `cmd_drop`.
  - EXEC: compute and register result/response → RESP. Nonzero `cmd_in` → `cmd_drop`.
  - RESP: drive `resp_out`/`data_out` for exactly one cycle.
    - Nonzero `cmd_in` in this state is accepted (latch cmd and op1, go to OPND2).
    - Otherwise → IDLE.
- Arithmetic, unsigned 32-bit:
  - Add: carry out of bit 31 → resp 2, data 0; else resp 1, sum.
  - Subtract: op2 > op1 → resp 2, data 0; else resp 1, op1 − op2; op1 == op2 → resp 1, data 0.
  - Shift left: op1 << op2[4:0], bits shifted out discarded, zero fill; resp 1. op2[31:5] ignored.
  - Shift right: logical, op1 >> op2[4:0]; resp 1.
  - Invalid command: resp 3, data 0. Operand 2 is still consumed (request is always two cycles).
- `busy` high in OPND2 and EXEC, low in IDLE and RESP.

## Timing
- Command+op1 at edge T, op2 at T+1, response registered and visible in cycle T+3 for one cycle.
- Minimum command spacing 3 cycles; a command presented in the RESP cycle yields a back-to-back response 3 cycles later.
- Reset values: `resp_out`=0, `data_out`=0, `busy`=0, `cmd_drop`=0, state IDLE.
- Reset asserted mid-request discards it: no response is ever emitted for it.
- `cmd_in` sampled on the same edge reset deasserts is ignored. First accept is possible on the edge after reset low.
- `cmd_drop` is registered and asserts the cycle after the offending input.

## Configuration
- `CALC1_SHIFT_EN` defined: commands 5 and 6 execute as above.
- Not defined: shifter logic is absent; commands 5 and 6 return resp 3, data 0 with the same latency.

## Test plan
- Reset then cmd 1, op1 0x0000_0001, op2 0x0000_0002 → cycle T+3: resp 1, data 0x0000_0003; next cycle resp 0, data 0.
- Add 0xFFFF_FFFF + 0x0000_0001 → resp 2, data 0. Sub 5 − 7 → resp 2, data 0. Sub 7 − 7 → resp 1, data 0.
- With `CALC1_SHIFT_EN`: shl 0x8000_0001 by 0x21 → resp 1, data 0x0000_0002. Shr 0x8000_0000 by 31 → resp 1, data 1. Without the macro: both → resp 3.
- Cmd 9, any operands → T+3: resp 3, data 0. Cmd 1 presented at T+1 and T+2 → `cmd_drop` pulses, a single response only.
- Back-to-back: second add issued in the RESP cycle → responses 3 cycles apart, both correct, `busy` pattern 1,1,0 per request.
- Reset asserted at T+2 of an add → no response at T+3; outputs 0. A new add after reset completes normally.
